// File: rtl/mem_bus_arbiter_pkg.sv
// Shared definitions for the Hack memory bus arbiter: default bus widths,
// master IDs, read-latency limits and the types used by the arbiter and the
// read tracker. Optional feature macro: MEM_ARB_LOCK_EN.
package mem_bus_arbiter_pkg;

    localparam int unsigned ADDR_W_DEF = 15;
    localparam int unsigned DATA_W_DEF = 16;

    localparam logic MID_CPU = 1'b0;
    localparam logic MID_DMA = 1'b1;

    localparam int unsigned RD_LAT_MIN = 1;
    localparam int unsigned RD_LAT_MAX = 4;

    // hold counter is wide enough for MAX_HOLD up to 255
    localparam int unsigned HOLD_W = 8;

    typedef enum logic [1:0] {
        WIN_NONE,
        WIN_M0,
        WIN_M1
    } winner_e;

    typedef struct packed {
        logic valid;
        logic owner;
    } rd_slot_t;

endpackage

// File: rtl/mem_bus_arbiter_if.sv
// Bus bundle between the two masters, the arbiter and the peripheral bus
// decode. The slave modport is the arbiter view; the master modport is the
// view of the requesters plus the memory returning mem_out.
// Optional feature macro: MEM_ARB_LOCK_EN (adds m1_lock).
import mem_bus_arbiter_pkg::*;

interface mem_bus_arbiter_if #(
    parameter int unsigned ADDR_W = ADDR_W_DEF,
    parameter int unsigned DATA_W = DATA_W_DEF
) ();

    logic              m0_req;
    logic              m0_we;
    logic [ADDR_W-1:0] m0_addr;
    logic [DATA_W-1:0] m0_wdata;
    logic              m0_gnt;
    logic              m0_rvalid;
    logic [DATA_W-1:0] m0_rdata;

    logic              m1_req;
    logic              m1_we;
    logic [ADDR_W-1:0] m1_addr;
    logic [DATA_W-1:0] m1_wdata;
    logic              m1_gnt;
    logic              m1_rvalid;
    logic [DATA_W-1:0] m1_rdata;
`ifdef MEM_ARB_LOCK_EN
    logic              m1_lock;
`endif

    logic [ADDR_W-1:0] mem_address;
    logic              mem_load;
    logic [DATA_W-1:0] mem_in;
    logic [DATA_W-1:0] mem_out;

    modport slave (
        input  m0_req, m0_we, m0_addr, m0_wdata,
        output m0_gnt, m0_rvalid, m0_rdata,
        input  m1_req, m1_we, m1_addr, m1_wdata,
`ifdef MEM_ARB_LOCK_EN
        input  m1_lock,
`endif
        output m1_gnt, m1_rvalid, m1_rdata,
        output mem_address, mem_load, mem_in,
        input  mem_out
    );

    modport master (
        output m0_req, m0_we, m0_addr, m0_wdata,
        input  m0_gnt, m0_rvalid, m0_rdata,
        output m1_req, m1_we, m1_addr, m1_wdata,
`ifdef MEM_ARB_LOCK_EN
        output m1_lock,
`endif
        input  m1_gnt, m1_rvalid, m1_rdata,
        input  mem_address, mem_load, mem_in,
        output mem_out
    );

endinterface

// File: rtl/mem_bus_arbiter_rd_tracker.sv
// Read ownership tracker: an RD_LAT-deep shift of {valid, owner} follows
// every issued read; when a read reaches the last stage, mem_out belongs to
// its owner, who gets a one-cycle rvalid and a held copy of the data.
import mem_bus_arbiter_pkg::*;

module mem_rd_tracker #(
    parameter int unsigned RD_LAT = 1,
    parameter int unsigned DATA_W = DATA_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              issue_valid,
    input  logic              issue_owner,
    input  logic [DATA_W-1:0] mem_out,
    output logic              m0_rvalid,
    output logic [DATA_W-1:0] m0_rdata,
    output logic              m1_rvalid,
    output logic [DATA_W-1:0] m1_rdata
);

    rd_slot_t [RD_LAT-1:0] pipe;
    rd_slot_t              done;
    logic [DATA_W-1:0]     m0_rdata_q;
    logic [DATA_W-1:0]     m1_rdata_q;

    // advance issued reads one stage per clock; reset drops anything in flight
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pipe <= '0;
        end else begin
            pipe[0] <= '{valid: issue_valid, owner: issue_owner};
            for (int unsigned i = 1; i < RD_LAT; i++) begin
                pipe[i] <= pipe[i-1];
            end
        end
    end

    assign done      = pipe[RD_LAT-1];
    assign m0_rvalid = done.valid && (done.owner == MID_CPU);
    assign m1_rvalid = done.valid && (done.owner == MID_DMA);

    // keep the last delivered word of each master until its next rvalid
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            m0_rdata_q <= '0;
            m1_rdata_q <= '0;
        end else begin
            if (m0_rvalid) m0_rdata_q <= mem_out;
            if (m1_rvalid) m1_rdata_q <= mem_out;
        end
    end

    // mem_out is only valid during the rvalid cycle, so it is forwarded
    // there and the held copy is shown otherwise
    assign m0_rdata = m0_rvalid ? mem_out : m0_rdata_q;
    assign m1_rdata = m1_rvalid ? mem_out : m1_rdata_q;

endmodule

// File: rtl/mem_bus_arbiter.sv
// Two-master arbiter for the 15-bit Hack memory bus. m0 (CPU) has priority,
// m1 (DMA) is protected from starvation by a hold counter, at most one
// transaction is issued per clock and read data is routed back to its issuer.
// Optional feature macro: MEM_ARB_LOCK_EN (m1 may lock the bus).
import mem_bus_arbiter_pkg::*;

module mem_bus_arbiter #(
    parameter int unsigned ADDR_W   = ADDR_W_DEF,
    parameter int unsigned DATA_W   = DATA_W_DEF,
    parameter int unsigned RD_LAT   = 1,
    parameter int unsigned MAX_HOLD = 8
) (
    input  logic            clk,
    input  logic            rst,
    mem_bus_arbiter_if.slave bus
);

    logic [HOLD_W-1:0] hold_cnt;
    winner_e           winner;
    logic              guard_trip;
    logic              lock_hold;
    logic              win_we;
    logic              rd_issue;
    logic              rd_owner;

`ifdef MEM_ARB_LOCK_EN
    logic m1_owned_q;

    // remember that m1 held the bus last cycle
    always_ff @(posedge clk or posedge rst) begin
        if (rst) m1_owned_q <= 1'b0;
        else     m1_owned_q <= bus.m1_gnt;
    end

    assign lock_hold = m1_owned_q && bus.m1_lock && bus.m1_req;
`else
    assign lock_hold = 1'b0;
`endif

    assign guard_trip = bus.m1_req && (hold_cnt == HOLD_W'(MAX_HOLD));

    // pick the winner; nothing is granted while reset is asserted
    always_comb begin
        winner = WIN_NONE;
        if (rst)                            winner = WIN_NONE;
        else if (lock_hold)                 winner = WIN_M1;
        else if (bus.m0_req && !guard_trip) winner = WIN_M0;
        else if (bus.m1_req)                winner = WIN_M1;
    end

    assign bus.m0_gnt = (winner == WIN_M0);
    assign bus.m1_gnt = (winner == WIN_M1);

    // route the winning master onto the bus; idle bus is all zero
    always_comb begin
        bus.mem_address = '0;
        bus.mem_load    = 1'b0;
        bus.mem_in      = '0;
        win_we          = 1'b0;
        case (winner)
            WIN_M0: begin
                bus.mem_address = bus.m0_addr;
                bus.mem_load    = bus.m0_we;
                bus.mem_in      = bus.m0_wdata;
                win_we          = bus.m0_we;
            end
            WIN_M1: begin
                bus.mem_address = bus.m1_addr;
                bus.mem_load    = bus.m1_we;
                bus.mem_in      = bus.m1_wdata;
                win_we          = bus.m1_we;
            end
            default: ;
        endcase
    end

    // count consecutive m0 wins that kept a requesting m1 waiting
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hold_cnt <= '0;
        end else if (bus.m1_gnt || !bus.m1_req) begin
            hold_cnt <= '0;
        end else if (bus.m0_gnt && (hold_cnt != HOLD_W'(MAX_HOLD))) begin
            hold_cnt <= hold_cnt + 1'b1;
        end
    end

    assign rd_issue = (winner != WIN_NONE) && !win_we;
    assign rd_owner = (winner == WIN_M1) ? MID_DMA : MID_CPU;

    mem_rd_tracker #(
        .RD_LAT (RD_LAT),
        .DATA_W (DATA_W)
    ) u_rd_tracker (
        .clk         (clk),
        .rst         (rst),
        .issue_valid (rd_issue),
        .issue_owner (rd_owner),
        .mem_out     (bus.mem_out),
        .m0_rvalid   (bus.m0_rvalid),
        .m0_rdata    (bus.m0_rdata),
        .m1_rvalid   (bus.m1_rvalid),
        .m1_rdata    (bus.m1_rdata)
    );

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Bench for mem_bus_arbiter: two instances (RD_LAT=1 and RD_LAT=2, MAX_HOLD=8)
// see identical master stimulus. Each has a memory model whose read data is a
// fixed function of the address. Expected reads go into per-instance queues;
// a negedge monitor pops and compares whenever an rvalid appears.
// Define MEM_ARB_LOCK_EN to include the bus-lock case.
module tb_mem_bus_arbiter;

    localparam int unsigned AW = 15;
    localparam int unsigned DW = 16;

    typedef struct packed {
        logic          owner;
        logic [AW-1:0] addr;
        int            issue;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   vectors = 0;
    int   miscompares = 0;
    exp_t q1[$];
    exp_t q2[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    mem_bus_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus1 ();
    mem_bus_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus2 ();

    mem_bus_arbiter #(.ADDR_W(AW), .DATA_W(DW), .RD_LAT(1), .MAX_HOLD(8)) dut1 (
        .clk(clk), .rst(rst), .bus(bus1));
    mem_bus_arbiter #(.ADDR_W(AW), .DATA_W(DW), .RD_LAT(2), .MAX_HOLD(8)) dut2 (
        .clk(clk), .rst(rst), .bus(bus2));

    function automatic logic [DW-1:0] fmem(input logic [AW-1:0] a);
        return {1'b0, a} ^ 16'h5A3C;
    endfunction

    // synchronous memory models with 1 and 2 cycles of read latency
    logic [AW-1:0] ap1;
    logic [AW-1:0] ap2a, ap2b;
    always @(posedge clk) begin
        ap1  <= bus1.mem_address;
        ap2a <= bus2.mem_address;
        ap2b <= ap2a;
    end
    assign bus1.mem_out = fmem(ap1);
    assign bus2.mem_out = fmem(ap2b);

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s cyc=%0d got=%h required=%h", name, cyc, act, exp);
        end
    endtask

    task automatic mon(input int d, input int lat, input logic rv0, input logic rv1,
                       input logic [DW-1:0] rd0, input logic [DW-1:0] rd1);
        exp_t e;
        int   n;
        if (rv0 || rv1) begin
            chk($sformatf("dut%0d_single_rvalid", d), {31'd0, rv0 && rv1}, 32'd0);
            n = (d == 1) ? q1.size() : q2.size();
            if (n == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL dut%0d_unexpected_rvalid cyc=%0d got owner m%0d, required none",
                         d, cyc, rv1);
            end else begin
                e = (d == 1) ? q1.pop_front() : q2.pop_front();
                chk($sformatf("dut%0d_rd_owner", d), {31'd0, rv1}, {31'd0, e.owner});
                chk($sformatf("dut%0d_rdata", d), {16'd0, rv1 ? rd1 : rd0}, {16'd0, fmem(e.addr)});
                chk($sformatf("dut%0d_rd_latency", d), cyc, e.issue + lat);
            end
        end
    endtask

    always @(negedge clk) begin
        mon(1, 1, bus1.m0_rvalid, bus1.m1_rvalid, bus1.m0_rdata, bus1.m1_rdata);
        mon(2, 2, bus2.m0_rvalid, bus2.m1_rvalid, bus2.m0_rdata, bus2.m1_rdata);
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input int m, input logic req, input logic we,
                         input logic [AW-1:0] a, input logic [DW-1:0] d);
        if (m == 0) begin
            bus1.m0_req = req; bus1.m0_we = we; bus1.m0_addr = a; bus1.m0_wdata = d;
            bus2.m0_req = req; bus2.m0_we = we; bus2.m0_addr = a; bus2.m0_wdata = d;
        end else begin
            bus1.m1_req = req; bus1.m1_we = we; bus1.m1_addr = a; bus1.m1_wdata = d;
            bus2.m1_req = req; bus2.m1_we = we; bus2.m1_addr = a; bus2.m1_wdata = d;
        end
    endtask

    task automatic exp_rd(input logic owner, input logic [AW-1:0] a);
        q1.push_back('{owner: owner, addr: a, issue: cyc});
        q2.push_back('{owner: owner, addr: a, issue: cyc});
    endtask

    task automatic chk_bus(input string tag, input logic g0, input logic g1, input logic ld,
                           input logic [AW-1:0] a, input logic [DW-1:0] din);
        chk({tag, "_d1_m0_gnt"}, {31'd0, bus1.m0_gnt}, {31'd0, g0});
        chk({tag, "_d1_m1_gnt"}, {31'd0, bus1.m1_gnt}, {31'd0, g1});
        chk({tag, "_d1_load"},   {31'd0, bus1.mem_load}, {31'd0, ld});
        chk({tag, "_d1_addr"},   {17'd0, bus1.mem_address}, {17'd0, a});
        chk({tag, "_d1_din"},    {16'd0, bus1.mem_in}, {16'd0, din});
        chk({tag, "_d2_m0_gnt"}, {31'd0, bus2.m0_gnt}, {31'd0, g0});
        chk({tag, "_d2_m1_gnt"}, {31'd0, bus2.m1_gnt}, {31'd0, g1});
        chk({tag, "_d2_load"},   {31'd0, bus2.mem_load}, {31'd0, ld});
        chk({tag, "_d2_addr"},   {17'd0, bus2.mem_address}, {17'd0, a});
        chk({tag, "_d2_din"},    {16'd0, bus2.mem_in}, {16'd0, din});
    endtask

    task automatic chk_rsp_zero(input string tag);
        chk({tag, "_d1_rvalid"}, {30'd0, bus1.m0_rvalid, bus1.m1_rvalid}, 32'd0);
        chk({tag, "_d2_rvalid"}, {30'd0, bus2.m0_rvalid, bus2.m1_rvalid}, 32'd0);
        chk({tag, "_d1_rdata"},  {bus1.m0_rdata, bus1.m1_rdata}, 32'd0);
        chk({tag, "_d2_rdata"},  {bus2.m0_rdata, bus2.m1_rdata}, 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog cyc=%0d got=running required=finished", cyc);
        $fatal(1);
    end

    initial begin
        drive(0, 1'b0, 1'b0, '0, '0);
        drive(1, 1'b0, 1'b0, '0, '0);
`ifdef MEM_ARB_LOCK_EN
        bus1.m1_lock = 1'b0;
        bus2.m1_lock = 1'b0;
`endif
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk_bus("reset", 1'b0, 1'b0, 1'b0, '0, '0);
        chk_rsp_zero("reset");
        step();
        rst = 1'b0;

        // 1: lone m0 read
        step();
        drive(0, 1'b1, 1'b0, 15'h0010, '0);
        @(negedge clk);
        chk_bus("t1", 1'b1, 1'b0, 1'b0, 15'h0010, '0);
        exp_rd(1'b0, 15'h0010);
        step();
        drive(0, 1'b0, 1'b0, '0, '0);
        repeat (3) step();

        // 2: lone m1 write; no rvalid, m0 rdata still held
        drive(1, 1'b1, 1'b1, 15'h4000, 16'hFFFF);
        @(negedge clk);
        chk_bus("t2", 1'b0, 1'b1, 1'b1, 15'h4000, 16'hFFFF);
        chk("t2_d1_m0_rdata_hold", {16'd0, bus1.m0_rdata}, {16'd0, fmem(15'h0010)});
        step();
        drive(1, 1'b0, 1'b0, '0, '0);
        @(negedge clk);
        chk_bus("t2_idle", 1'b0, 1'b0, 1'b0, '0, '0);

        // 3: both request continuously; 8 m0 grants then one m1 grant
        step();
        drive(0, 1'b1, 1'b1, 15'h0111, 16'hAAAA);
        drive(1, 1'b1, 1'b1, 15'h0222, 16'h5555);
        for (int k = 0; k < 27; k++) begin
            @(negedge clk);
            if (k % 9 == 8) chk_bus($sformatf("t3_k%0d", k), 1'b0, 1'b1, 1'b1, 15'h0222, 16'h5555);
            else            chk_bus($sformatf("t3_k%0d", k), 1'b1, 1'b0, 1'b1, 15'h0111, 16'hAAAA);
            step();
        end
        drive(0, 1'b0, 1'b0, '0, '0);
        drive(1, 1'b0, 1'b0, '0, '0);
        step();

        // 4: interleaved reads in consecutive cycles, then a simultaneous pair
        drive(0, 1'b1, 1'b0, 15'h0001, '0);
        @(negedge clk);
        chk_bus("t4a", 1'b1, 1'b0, 1'b0, 15'h0001, '0);
        exp_rd(1'b0, 15'h0001);
        step();
        drive(0, 1'b0, 1'b0, '0, '0);
        drive(1, 1'b1, 1'b0, 15'h6000, '0);
        @(negedge clk);
        chk_bus("t4b", 1'b0, 1'b1, 1'b0, 15'h6000, '0);
        exp_rd(1'b1, 15'h6000);
        step();
        drive(1, 1'b0, 1'b0, '0, '0);
        drive(0, 1'b1, 1'b0, 15'h0002, '0);
        @(negedge clk);
        chk_bus("t4c", 1'b1, 1'b0, 1'b0, 15'h0002, '0);
        exp_rd(1'b0, 15'h0002);
        step();
        drive(0, 1'b1, 1'b0, 15'h0003, '0);
        drive(1, 1'b1, 1'b0, 15'h6001, '0);
        @(negedge clk);
        chk_bus("t4d", 1'b1, 1'b0, 1'b0, 15'h0003, '0);
        exp_rd(1'b0, 15'h0003);
        step();
        drive(0, 1'b0, 1'b0, '0, '0);
        @(negedge clk);
        chk_bus("t4e", 1'b0, 1'b1, 1'b0, 15'h6001, '0);
        exp_rd(1'b1, 15'h6001);
        step();
        drive(1, 1'b0, 1'b0, '0, '0);
        repeat (4) step();

        // 5: reset one cycle after an m1 read issue drops the read
        drive(1, 1'b1, 1'b0, 15'h0123, '0);
        @(negedge clk);
        chk_bus("t5_issue", 1'b0, 1'b1, 1'b0, 15'h0123, '0);
        step();
        rst = 1'b1;
        drive(1, 1'b0, 1'b0, '0, '0);
        drive(0, 1'b1, 1'b1, 15'h0005, 16'h0007);
        @(negedge clk);
        chk_bus("t5_rst", 1'b0, 1'b0, 1'b0, '0, '0);
        chk_rsp_zero("t5_rst");
        repeat (2) step();
        rst = 1'b0;
        @(negedge clk);
        chk_bus("t5_post", 1'b1, 1'b0, 1'b1, 15'h0005, 16'h0007);
        step();
        drive(0, 1'b0, 1'b0, '0, '0);
        repeat (4) step();

`ifdef MEM_ARB_LOCK_EN
        // 6: m1 locks the bus for 5 grants while m0 waits
        drive(1, 1'b1, 1'b1, 15'h0300, 16'h1234);
        bus1.m1_lock = 1'b1;
        bus2.m1_lock = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk_bus($sformatf("t6_lock%0d", k), 1'b0, 1'b1, 1'b1, 15'h0300, 16'h1234);
            step();
            drive(0, 1'b1, 1'b1, 15'h0400, 16'h4321);
        end
        bus1.m1_lock = 1'b0;
        bus2.m1_lock = 1'b0;
        @(negedge clk);
        chk_bus("t6_release", 1'b1, 1'b0, 1'b1, 15'h0400, 16'h4321);
        step();
        drive(0, 1'b0, 1'b0, '0, '0);
        drive(1, 1'b0, 1'b0, '0, '0);
        repeat (3) step();
`endif

        chk("d1_reads_outstanding", q1.size(), 32'd0);
        chk("d2_reads_outstanding", q2.size(), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
